// File: rtl/ss_pkg.sv
// Shared types and constants for the serial sequence generator.
// The default pattern is the sequence the detector looks for.
package ss_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_GAP_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } ss_state_t;

  // Counter width for a count range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ss_generator_if.sv
// Control/data bundle between a controller (master) and the generator (slave).
// start/pattern/repeat_count are sampled only while the generator is idle; the rest are registered outputs.
interface ss_generator_if
  import ss_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int REP_W = 4
) ();

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] repeat_count;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  ss_state_t        state;

  modport master (
    output start, pattern, repeat_count,
    input  out, out_valid, busy, done, state
  );

  modport slave (
    input  start, pattern, repeat_count,
    output out, out_valid, busy, done, state
  );

endinterface

// File: rtl/ss_piso.sv
// Parallel-in serial-out register, MSB first, zero fill on shift.
// Load takes priority over shift.
module ss_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/ss_generator.sv
// Serial sequence generator: sends a latched pattern MSB-first, optionally
// repeated with an idle gap, and signals busy and a one-cycle done pulse.
module ss_generator
  import ss_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input logic           clock,
  input logic           reset,
  ss_generator_if.slave bus
);

  localparam int BIT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  ss_state_t        state;
  logic [WIDTH-1:0] hold;
  logic [REP_W-1:0] rep_left;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             load;
  logic             shift;
  logic [WIDTH-1:0] load_data;
  logic             serial_bit;

  // The shift register drains to all zeros after the last bit, so its MSB
  // already reads 0 in every non-SHIFT state and can drive out directly.
  always_comb begin
    load      = 1'b0;
    shift     = 1'b0;
    load_data = hold;
    case (state)
      ST_IDLE: begin
        load      = bus.start;
        load_data = bus.pattern;
      end
      ST_SHIFT: begin
        shift = 1'b1;
        load  = (bit_cnt == LAST_BIT) && (rep_left != '0) && (GAP == 0);
      end
      ST_GAP_WAIT: load = (gap_cnt == LAST_GAP);
      default: ;
    endcase
  end

  ss_piso #(.WIDTH(WIDTH)) u_piso (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (load_data),
    .msb   (serial_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold        <= '0;
      rep_left    <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            hold        <= bus.pattern;
            rep_left    <= bus.repeat_count;
            bit_cnt     <= '0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (rep_left == '0) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state       <= ST_DONE;
            end else if (GAP == 0) begin
              rep_left <= rep_left - REP_W'(1);
            end else begin
              out_valid_q <= 1'b0;
              gap_cnt     <= '0;
              state       <= ST_GAP_WAIT;
            end
          end
        end
        ST_GAP_WAIT: begin
          if (gap_cnt == LAST_GAP) begin
            rep_left    <= rep_left - REP_W'(1);
            out_valid_q <= 1'b1;
            state       <= ST_SHIFT;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out       = serial_bit;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_ss_generator.sv
// Bench for ss_generator: one GAP=0 and one GAP=2 instance, per-cycle
// expected {out_valid, out, busy, done} vectors held in a scoreboard queue.
module tb_ss_generator;
  import ss_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ss_generator_if #(.WIDTH(4), .REP_W(4)) if0 ();
  ss_generator_if #(.WIDTH(4), .REP_W(4)) if2 ();

  ss_generator #(.WIDTH(4), .REP_W(4), .GAP(0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
  ss_generator #(.WIDTH(4), .REP_W(4), .GAP(2)) dut2 (.clock(clock), .reset(reset), .bus(if2));

  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [3:0] sample(input int sel);
    if (sel == 2) return {if2.out_valid, if2.out, if2.busy, if2.done};
    return {if0.out_valid, if0.out, if0.busy, if0.done};
  endfunction

  // Reference model: one vector per cycle after accept, ending with the done cycle.
  function automatic void push_stream(input logic [3:0] pat, input int rep, input int gap);
    for (int r = 0; r <= rep; r++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
      if (r < rep) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    reset = 1'b1;
    if0.start = 1'b1; if0.pattern = DEFAULT_PATTERN; if0.repeat_count = '0;
    if2.start = 1'b1; if2.pattern = DEFAULT_PATTERN; if2.repeat_count = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 2) begin
        n_checks++;
        if (dut0.u_piso.sreg !== 4'b0000) begin
          n_fail++; $display("FAIL reset_released sreg: got %b required 0000", dut0.u_piso.sreg);
        end
      end
      got = sample(0); n_checks++;
      if (got !== 4'b0000) begin n_fail++; $display("FAIL reset dut0 cycle %0d: got %b required 0000", i, got); end
      got = sample(2); n_checks++;
      if (got !== 4'b0000) begin n_fail++; $display("FAIL reset dut2 cycle %0d: got %b required 0000", i, got); end
      n_checks++;
      if (if0.state !== ST_IDLE) begin n_fail++; $display("FAIL reset state cycle %0d: got %0d required %0d", i, if0.state, ST_IDLE); end
      if (i == 1) begin reset = 1'b0; if0.start = 1'b0; if2.start = 1'b0; end
    end
  endtask

  task automatic test_single();
    logic [3:0] got, exp; int c = 0;
    push_stream(4'b1011, 0, 0); exp_q.push_back(4'b0000);
    @(negedge clock); if0.pattern = 4'b1011; if0.repeat_count = 4'd0; if0.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock); c++; if0.start = 1'b0;
      got = sample(0); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL single cycle %0d: got %b required %b", c, got, exp); end
    end
  endtask

  task automatic test_repeats(input logic [3:0] pat, input int rep, input string name);
    logic [3:0] got, exp; int c = 0;
    push_stream(pat, rep, 0); exp_q.push_back(4'b0000);
    @(negedge clock); if0.pattern = pat; if0.repeat_count = 4'(rep); if0.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock); c++; if0.start = 1'b0;
      got = sample(0); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s cycle %0d: got %b required %b", name, c, got, exp); end
    end
  endtask

  task automatic test_gap(input logic [3:0] pat, input int rep, input string name);
    logic [3:0] got, exp; int c = 0;
    push_stream(pat, rep, 2); exp_q.push_back(4'b0000);
    @(negedge clock); if2.pattern = pat; if2.repeat_count = 4'(rep); if2.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock); c++; if2.start = 1'b0;
      got = sample(2); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL %s cycle %0d: got %b required %b", name, c, got, exp); end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [3:0] got, exp; int c = 0; int n_done = 0;
    push_stream(4'b1011, 0, 0);
    repeat (3) exp_q.push_back(4'b0000);
    @(negedge clock); if0.pattern = 4'b1011; if0.repeat_count = 4'd0; if0.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock); c++;
      got = sample(0); exp = exp_q.pop_front(); n_checks++;
      n_done += int'(got[0]);
      if (got !== exp) begin n_fail++; $display("FAIL ignored cycle %0d: got %b required %b", c, got, exp); end
      if (c == 2) begin if0.start = 1'b1; if0.pattern = 4'b0000; if0.repeat_count = 4'd3; end
      else if0.start = 1'b0;
    end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL ignored done_count: got %0d required 1", n_done); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, exp; int c = 0;
    exp_q.push_back(4'b1110); exp_q.push_back(4'b1010);
    repeat (4) exp_q.push_back(4'b0000);
    @(negedge clock); if0.pattern = 4'b1011; if0.repeat_count = 4'd1; if0.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock); c++; if0.start = 1'b0;
      got = sample(0); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_mid cycle %0d: got %b required %b", c, got, exp); end
      if (c == 2) reset = 1'b1;
      else reset = 1'b0;
    end
    n_checks++;
    if (if0.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_mid state: got %0d required %0d", if0.state, ST_IDLE); end
    test_repeats(4'b1011, 0, "reset_mid_resend");
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp; int c = 0;
    push_stream(4'b1011, 0, 0); exp_q.push_back(4'b0000);
    push_stream(4'b0110, 0, 0); exp_q.push_back(4'b0000);
    @(negedge clock); if0.pattern = 4'b1011; if0.repeat_count = 4'd0; if0.start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clock); c++;
      got = sample(0); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL back_to_back cycle %0d: got %b required %b", c, got, exp); end
      if (c == 6) if0.pattern = 4'b0110;
      if (c == 7) if0.start = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [3:0] pat; int rep;
    for (int i = 0; i < 4; i++) begin
      pat = 4'($urandom_range(0, 15));
      rep = $urandom_range(0, 3);
      test_gap(pat, rep, "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeats(4'b1011, 2, "repeats");
    test_gap(4'b0110, 1, "gap");
    test_gap(4'b1001, 0, "gap_norep");
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    test_repeats(4'b1001, 15, "max_repeat");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
